scc_channel_mixer: RTL and testbench



---
 rtl/scc_channel_mixer_pkg.sv | 12 +
 rtl/scc_channel_mixer_accumulator.sv | 35 +++
 rtl/scc_channel_mixer.sv | 137 +++++++++++++
 tb/tb_scc_channel_mixer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/scc_channel_mixer_pkg.sv
// Shared widths and FSM state encoding for the SCC channel mixer.
package scc_channel_mixer_pkg;
  localparam int SCC_CHANNELS = 5;
  localparam int SCC_SAMPLE_W = 8;
  localparam int SCC_MIX_W    = 11;

  typedef enum logic [1:0] {
    MIX_IDLE  = 2'd0,
    MIX_ACCUM = 2'd1,
    MIX_DONE  = 2'd2
  } mix_state_e;
endpackage

// File: rtl/scc_channel_mixer_accumulator.sv
// Frame accumulator: sign-extends the slot sample, gates it by its enable and
// clears, loads or adds under control of the mixer FSM.
module scc_mix_accumulator #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 11
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        clear_i,
  input  logic                        load_i,
  input  logic                        add_i,
  input  logic                        enable_i,
  input  logic signed [IN_WIDTH-1:0]  sample_i,
  output logic signed [OUT_WIDTH-1:0] sum_o
);
  logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0] gated;

  assign gated = enable_i ? {{(OUT_WIDTH-IN_WIDTH){sample_i[IN_WIDTH-1]}}, sample_i}
                          : '0;
  assign sum_o = acc_q + gated;

  // Load wins over clear so a slot-0 strobe in the DONE cycle starts a new frame.
  always_comb begin
    acc_d = acc_q;
    if (load_i)       acc_d = gated;
    else if (clear_i) acc_d = '0;
    else if (add_i)   acc_d = sum_o;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) acc_q <= '0;
    else         acc_q <= acc_d;
  end
endmodule

// File: rtl/scc_channel_mixer.sv
// Sums the enabled SCC channel slots of each frame into one registered sample,
// checking that slots arrive in order 0..CHANNELS-1.
module scc_channel_mixer
  import scc_channel_mixer_pkg::*;
#(
  parameter int CHANNELS  = SCC_CHANNELS,
  parameter int IN_WIDTH  = SCC_SAMPLE_W,
  parameter int OUT_WIDTH = SCC_MIX_W
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic signed [IN_WIDTH-1:0]  channel,
  input  logic                        ch_strobe,
  input  logic [2:0]                  ch_index,
  input  logic [CHANNELS-1:0]         reg_ch_enable,
  output logic signed [OUT_WIDTH-1:0] mix_out,
  output logic                        mix_valid,
  output logic                        frame_error,
  input  logic                        error_clear,
  output mix_state_e                  state_o
);
  // Handshake: ch_strobe is a one-cycle valid with no back-pressure; channel and
  // ch_index are only meaningful in that cycle. mix_valid is a one-cycle valid
  // qualifying mix_out, which then holds until the next completed frame.
  mix_state_e                  state_q, state_d;
  logic [2:0]                  exp_q, exp_d;
  logic signed [OUT_WIDTH-1:0] mix_q;
  logic                        err_q;
  logic                        acc_clear, acc_load, acc_add, err_set, out_load;
  logic                        en_bit;
  logic [7:0]                  en_ext;
  logic signed [OUT_WIDTH-1:0] sum;

  assign en_ext = 8'(reg_ch_enable);
  assign en_bit = en_ext[ch_index];

  scc_mix_accumulator #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_acc (
    .clk     (clk),
    .nreset  (nreset),
    .clear_i (acc_clear),
    .load_i  (acc_load),
    .add_i   (acc_add),
    .enable_i(en_bit),
    .sample_i(channel),
    .sum_o   (sum)
  );

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    acc_clear = 1'b0;
    acc_load  = 1'b0;
    acc_add   = 1'b0;
    err_set   = 1'b0;
    out_load  = 1'b0;
    case (state_q)
      MIX_IDLE: begin
        if (ch_strobe) begin
          if (ch_index == 3'd0) begin
            acc_load = 1'b1;
            exp_d    = 3'd1;
            state_d  = MIX_ACCUM;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      MIX_ACCUM: begin
        if (ch_strobe) begin
          if (ch_index == exp_q) begin
            acc_add = 1'b1;
            if (ch_index == 3'(CHANNELS-1)) begin
              out_load = 1'b1;
              state_d  = MIX_DONE;
            end else begin
              exp_d = exp_q + 3'd1;
            end
          end else if (ch_index == 3'd0) begin
            // Early restart: drop the partial frame and begin again from slot 0.
            err_set  = 1'b1;
            acc_load = 1'b1;
            exp_d    = 3'd1;
          end else begin
            err_set   = 1'b1;
            acc_clear = 1'b1;
            exp_d     = 3'd0;
            state_d   = MIX_IDLE;
          end
        end
      end
      MIX_DONE: begin
        acc_clear = 1'b1;
        exp_d     = 3'd0;
        state_d   = MIX_IDLE;
        if (ch_strobe) begin
          if (ch_index == 3'd0) begin
            acc_load = 1'b1;
            exp_d    = 3'd1;
            state_d  = MIX_ACCUM;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: begin
        acc_clear = 1'b1;
        exp_d     = 3'd0;
        state_d   = MIX_IDLE;
      end
    endcase
  end

  // mix_out captures the completed sum on the last-slot edge so it is visible
  // together with mix_valid during the DONE cycle.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= MIX_IDLE;
      exp_q   <= 3'd0;
      mix_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      if (out_load)         mix_q <= sum;
      if (err_set)          err_q <= 1'b1;
      else if (error_clear) err_q <= 1'b0;
    end
  end

  assign mix_out     = mix_q;
  assign mix_valid   = (state_q == MIX_DONE);
  assign frame_error = err_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_scc_channel_mixer.sv
// Directed bench for scc_channel_mixer with hand-computed frame sums.
module tb_scc_channel_mixer;
  import scc_channel_mixer_pkg::*;

  logic              clk = 1'b0;
  logic              nreset;
  logic signed [7:0] channel;
  logic              ch_strobe;
  logic [2:0]        ch_index;
  logic [4:0]        reg_ch_enable;
  logic signed [10:0] mix_out;
  logic              mix_valid;
  logic              frame_error;
  logic              error_clear;
  mix_state_e        state_o;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;
  int v0;

  scc_channel_mixer dut (
    .clk          (clk),
    .nreset       (nreset),
    .channel      (channel),
    .ch_strobe    (ch_strobe),
    .ch_index     (ch_index),
    .reg_ch_enable(reg_ch_enable),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .frame_error  (frame_error),
    .error_clear  (error_clear),
    .state_o      (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (mix_valid) valid_cnt++;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic strobe(input int idx, input int val);
    ch_index  = 3'(idx);
    channel   = 8'(val);
    ch_strobe = 1'b1;
    @(posedge clk); #1;
    ch_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame(input int a, input int b, input int c, input int d, input int e);
    strobe(0, a); strobe(1, b); strobe(2, c); strobe(3, d); strobe(4, e);
  endtask

  initial begin
    nreset = 1'b0; channel = '0; ch_strobe = 1'b0; ch_index = '0;
    reg_ch_enable = 5'b11111; error_clear = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_mix_out", int'(mix_out), 0);
    check("rst_valid", int'(mix_valid), 0);
    check("rst_err", int'(frame_error), 0);
    check("rst_state", int'(state_o), int'(MIX_IDLE));
    nreset = 1'b1;
    idle(1);

    // full-scale positive frame, single valid pulse one cycle after slot 4
    v0 = valid_cnt;
    strobe(0, 127); strobe(1, 127); strobe(2, 127); strobe(3, 127);
    check("f1_no_early_valid", int'(mix_valid), 0);
    strobe(4, 127);
    check("f1_valid", int'(mix_valid), 1);
    check("f1_sum", int'(mix_out), 635);
    idle(1);
    check("f1_valid_drop", int'(mix_valid), 0);
    check("f1_hold", int'(mix_out), 635);
    check("f1_pulses", valid_cnt - v0, 1);

    // negative full scale with slots 1 and 3 muted
    reg_ch_enable = 5'b10101;
    v0 = valid_cnt;
    frame(-128, -128, -128, -128, -128);
    check("f2_sum", int'(mix_out), -384);
    idle(2);
    check("f2_pulses", valid_cnt - v0, 1);
    reg_ch_enable = 5'b11111;

    // skipped slot aborts the frame without touching mix_out
    v0 = valid_cnt;
    strobe(0, 50); strobe(1, 50); strobe(3, 50);
    check("skip_err", int'(frame_error), 1);
    check("skip_state", int'(state_o), int'(MIX_IDLE));
    idle(2);
    check("skip_hold", int'(mix_out), -384);
    check("skip_no_valid", valid_cnt - v0, 0);
    frame(10, 20, 30, 40, 50);
    check("clean_sum", int'(mix_out), 150);

    // error_clear alone, then together with a new violation
    error_clear = 1'b1; idle(1); error_clear = 1'b0;
    check("err_cleared", int'(frame_error), 0);
    error_clear = 1'b1; strobe(2, 0); error_clear = 1'b0;
    check("err_set_wins", int'(frame_error), 1);
    error_clear = 1'b1; idle(1); error_clear = 1'b0;

    // back-to-back frames, next slot 0 lands in the DONE cycle
    v0 = valid_cnt;
    frame(1, 1, 1, 1, 1);
    check("b2b_a_sum", int'(mix_out), 5);
    check("b2b_a_valid", int'(mix_valid), 1);
    frame(2, 2, 2, 2, 2);
    check("b2b_b_sum", int'(mix_out), 10);
    check("b2b_b_valid", int'(mix_valid), 1);
    idle(1);
    check("b2b_pulses", valid_cnt - v0, 2);
    check("b2b_no_err", int'(frame_error), 0);

    // early restart discards the partial frame; idle gaps between strobes
    strobe(0, 100); strobe(1, 100); strobe(2, 100);
    strobe(0, 1);
    check("restart_err", int'(frame_error), 1);
    check("restart_state", int'(state_o), int'(MIX_ACCUM));
    idle(2); strobe(1, 2); idle(1); strobe(2, 3); strobe(3, 4); idle(3); strobe(4, 5);
    check("restart_sum", int'(mix_out), 15);

    // out-of-range slot index mid-frame
    error_clear = 1'b1; idle(1); error_clear = 1'b0;
    strobe(0, 9); strobe(1, 9); strobe(7, 9);
    check("oor_err", int'(frame_error), 1);
    check("oor_state", int'(state_o), int'(MIX_IDLE));

    // enable change mid-frame only affects later slots
    frame(0, 0, 0, 0, 0);
    reg_ch_enable = 5'b11111;
    strobe(0, 7); strobe(1, 7); reg_ch_enable = 5'b00011;
    strobe(2, 7); strobe(3, 7); strobe(4, 7);
    check("en_change_sum", int'(mix_out), 14);
    reg_ch_enable = 5'b11111;

    // asynchronous reset mid-frame
    idle(1);
    strobe(0, 10); strobe(1, 10); strobe(2, 10);
    nreset = 1'b0; #1;
    check("arst_mix_out", int'(mix_out), 0);
    check("arst_state", int'(state_o), int'(MIX_IDLE));
    check("arst_err", int'(frame_error), 0);
    @(posedge clk); #1; nreset = 1'b1;
    v0 = valid_cnt;
    strobe(3, 10); strobe(4, 10);
    check("post_rst_err", int'(frame_error), 1);
    check("post_rst_no_valid", valid_cnt - v0, 0);
    frame(5, 6, 7, 8, 9);
    check("post_rst_sum", int'(mix_out), 35);
    check("post_rst_valid", int'(mix_valid), 1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
